// File: rtl/rst_seq.sv
// rst_seq: power-up and soft-reset sequencer.
//
// Keeps every downstream reset domain in reset for a fixed hold period, then
// waits for PLL lock. After lock it releases the per-subsystem resets one at a
// time, in index order. Each release needs a minimum gap and that stage's ready
// acknowledge. A lock timeout or an ack timeout parks the block in FAULT. Lock
// loss or a soft request restarts the whole sequence.
//
// Ports:
//   clk          in   system clock, all logic on the rising edge
//   rst          in   synchronous active-high reset
//   pll_locked   in   PLL lock status, already synchronous to clk
//   soft_rst_req in   single-cycle request to restart the sequence
//   stage_ack    in   per-stage ready; bit k high when subsystem k is out of reset
//   rst_out      out  active-high reset per subsystem (registered)
//   all_ready    out  high only in RUN (registered)
//   fault        out  high only in FAULT (registered)
//   fault_code   out  01 lock timeout, 10 ack timeout, 00 otherwise
//   state_dbg    out  HOLD=0, WAIT_LOCK=1, RELEASE=2, RUN=3, FAULT=4
//   stage_idx    out  stage currently being released; 0 outside RELEASE
module rst_seq #(
  parameter int N_STAGES     = 4,
  parameter int HOLD_CYC     = 16,
  parameter int STAGE_GAP    = 8,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int ACK_TIMEOUT  = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pll_locked,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic [N_STAGES-1:0] rst_out,
  output logic                all_ready,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [2:0]          state_dbg,
  output logic [2:0]          stage_idx
);

  // The counter only ever reaches (limit-1) of the longest timed state, so
  // clog2 of the largest limit is enough to never wrap.
  localparam int MAX_A  = (HOLD_CYC > LOCK_TIMEOUT) ? HOLD_CYC : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [2:0]    LAST_IDX  = 3'(N_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_RELEASE   = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [2:0]          idx_n;
  logic [1:0]          code_n;
  logic [N_STAGES-1:0] rst_out_n;
  logic                all_ready_n;
  logic                fault_n;
  logic                ack_cur;

  // Next-state logic. Every output register is computed from the next state,
  // so each output changes on the same edge as the transition that causes it.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = stage_idx;
    code_n      = fault_code;
    ack_cur     = 1'b0;
    rst_out_n   = '1;
    all_ready_n = 1'b0;
    fault_n     = 1'b0;

    // Only the ack of the stage currently being released matters.
    for (int k = 0; k < N_STAGES; k++) begin
      if (stage_idx == 3'(k)) ack_cur = stage_ack[k];
    end

    if (soft_rst_req) begin
      state_n = S_HOLD;
      cnt_n   = '0;
      idx_n   = '0;
      code_n  = 2'b00;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (pll_locked) begin
            state_n = S_RELEASE;
            cnt_n   = '0;
            idx_n   = '0;
          end else if (cnt == LOCK_LAST) begin
            state_n = S_FAULT;
            cnt_n   = '0;
            code_n  = 2'b01;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RELEASE: begin
          // Advance is checked before timeout so a coincident ack still wins.
          if (!pll_locked) begin
            state_n = S_HOLD;
            cnt_n   = '0;
            idx_n   = '0;
          end else if ((cnt >= GAP_LAST) && ack_cur) begin
            cnt_n = '0;
            if (stage_idx == LAST_IDX) begin
              state_n = S_RUN;
              idx_n   = '0;
            end else begin
              idx_n = stage_idx + 3'd1;
            end
          end else if (cnt == ACK_LAST) begin
            state_n = S_FAULT;
            cnt_n   = '0;
            idx_n   = '0;
            code_n  = 2'b10;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (!pll_locked) begin
            state_n = S_HOLD;
            cnt_n   = '0;
          end
        end
        S_FAULT: begin
          // Lock changes are ignored; only reset or a soft request leaves.
        end
        default: begin
          state_n = S_HOLD;
          cnt_n   = '0;
          idx_n   = '0;
          code_n  = 2'b00;
        end
      endcase
    end

    // In RELEASE, stages up to and including the current index are out of
    // reset; every other state holds all resets except RUN.
    for (int k = 0; k < N_STAGES; k++) begin
      if (state_n == S_RELEASE) rst_out_n[k] = (3'(k) > idx_n);
      else                      rst_out_n[k] = (state_n != S_RUN);
    end
    all_ready_n = (state_n == S_RUN);
    fault_n     = (state_n == S_FAULT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HOLD;
      cnt        <= '0;
      stage_idx  <= '0;
      rst_out    <= '1;
      all_ready  <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      stage_idx  <= idx_n;
      rst_out    <= rst_out_n;
      all_ready  <= all_ready_n;
      fault      <= fault_n;
      fault_code <= code_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: scoreboard bench for rst_seq.
//
// The stimulus process pushes expected output snapshots, each tagged with the
// clock edge after which they must hold, into a queue. A separate monitor
// samples on the falling edge and pops and compares any snapshot that is due.
// Edge numbers are relative to R, the last edge that sampled rst=1. The DUT
// sits in HOLD from that edge, so WAIT_LOCK appears at R+16.
module tb_rst_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [3:0] stage_ack;
  logic [3:0] rst_out;
  logic       all_ready;
  logic       fault;
  logic [1:0] fault_code;
  logic [2:0] state_dbg;
  logic [2:0] stage_idx;

  logic [3:0] ack_mask = 4'b0000;
  logic [3:0] ack_force = 4'b0000;

  typedef struct {
    int          cyc;
    string       name;
    logic [13:0] exp;
  } exp_t;

  exp_t q[$];
  exp_t head;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   R;
  int   H;
  int   H2;

  rst_seq dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .stage_ack    (stage_ack),
    .rst_out      (rst_out),
    .all_ready    (all_ready),
    .fault        (fault),
    .fault_code   (fault_code),
    .state_dbg    (state_dbg),
    .stage_idx    (stage_idx)
  );

  // Acks model subsystems that come out of reset as soon as released,
  // filtered by a mask, plus a forced pattern for early/late ack cases.
  assign stage_ack = (~rst_out & ack_mask) | ack_force;

  // 100 MHz clock and an edge counter used to schedule expectations.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Compares one due snapshot against the DUT outputs.
  task automatic checkOutput(input exp_t e);
    logic [13:0] act;
    act = {rst_out, all_ready, fault, fault_code, state_dbg, stage_idx};
    total++;
    if (e.cyc != cyc) begin
      bad++;
      $display("[TB] FAIL %s: due at edge %0d but reached at edge %0d", e.name, e.cyc, cyc);
    end else if (act !== e.exp) begin
      bad++;
      $display("[TB] FAIL %s: got rst_out=%b rdy=%b flt=%b code=%b st=%0d idx=%0d, want rst_out=%b rdy=%b flt=%b code=%b st=%0d idx=%0d",
               e.name, act[13:10], act[9], act[8], act[7:6], act[5:3], act[2:0],
               e.exp[13:10], e.exp[9], e.exp[8], e.exp[7:6], e.exp[5:3], e.exp[2:0]);
    end
  endtask

  // Monitor: on each falling edge, pop every snapshot that is due.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      head = q.pop_front();
      checkOutput(head);
    end
  end

  // Pushes an expected snapshot for the given edge.
  task automatic expectAt(input int c, input string nm, input logic [3:0] ro,
                          input logic ar, input logic ft, input logic [1:0] fc,
                          input logic [2:0] st, input logic [2:0] ix);
    exp_t e;
    e.cyc  = c;
    e.name = nm;
    e.exp  = {ro, ar, ft, fc, st, ix};
    q.push_back(e);
  endtask

  // Waits until the given edge has passed, then settles 1 ns past it.
  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the lock input and the ack mask.
  task automatic applyStimulus(input logic lock, input logic [3:0] mask);
    pll_locked = lock;
    ack_mask   = mask;
  endtask

  // Two reset edges, then release; R marks the last edge that saw rst=1.
  task automatic applyReset();
    rst          = 1'b1;
    soft_rst_req = 1'b0;
    ack_force    = 4'b0000;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    R   = cyc;
    rst = 1'b0;
  endtask

  // Directed scenarios.
  initial begin
    // Nominal sequence followed by lock loss in RUN and a full re-run.
    applyReset();
    applyStimulus(1'b1, 4'b1111);
    H = R + 51;
    expectAt(R,      "t1_reset",      4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    expectAt(R + 15, "t1_hold_end",   4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    expectAt(R + 16, "t1_wait_lock",  4'b1111, 0, 0, 2'b00, 3'd1, 3'd0);
    expectAt(R + 17, "t1_stage0",     4'b1110, 0, 0, 2'b00, 3'd2, 3'd0);
    expectAt(R + 24, "t1_gap0",       4'b1110, 0, 0, 2'b00, 3'd2, 3'd0);
    expectAt(R + 25, "t1_stage1",     4'b1100, 0, 0, 2'b00, 3'd2, 3'd1);
    expectAt(R + 33, "t1_stage2",     4'b1000, 0, 0, 2'b00, 3'd2, 3'd2);
    expectAt(R + 41, "t1_stage3",     4'b0000, 0, 0, 2'b00, 3'd2, 3'd3);
    expectAt(R + 48, "t1_pre_run",    4'b0000, 0, 0, 2'b00, 3'd2, 3'd3);
    expectAt(R + 49, "t1_run",        4'b0000, 1, 0, 2'b00, 3'd3, 3'd0);
    expectAt(R + 50, "t4_run_kept",   4'b0000, 1, 0, 2'b00, 3'd3, 3'd0);
    expectAt(H,      "t4_lock_loss",  4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    expectAt(H + 16, "t4_wait_lock",  4'b1111, 0, 0, 2'b00, 3'd1, 3'd0);
    expectAt(H + 17, "t4_stage0",     4'b1110, 0, 0, 2'b00, 3'd2, 3'd0);
    expectAt(H + 41, "t4_stage3",     4'b0000, 0, 0, 2'b00, 3'd2, 3'd3);
    expectAt(H + 49, "t4_run",        4'b0000, 1, 0, 2'b00, 3'd3, 3'd0);
    stepTo(R + 50);
    pll_locked = 1'b0;
    stepTo(H);
    pll_locked = 1'b1;
    stepTo(H + 50);

    // Lock never arrives; lock rising in FAULT is ignored; soft request exits.
    applyReset();
    applyStimulus(1'b0, 4'b1111);
    expectAt(R + 16,   "t2_wait_lock",    4'b1111, 0, 0, 2'b00, 3'd1, 3'd0);
    expectAt(R + 1039, "t2_pre_timeout",  4'b1111, 0, 0, 2'b00, 3'd1, 3'd0);
    expectAt(R + 1040, "t2_lock_timeout", 4'b1111, 0, 1, 2'b01, 3'd4, 3'd0);
    expectAt(R + 1042, "t2_fault_held",   4'b1111, 0, 1, 2'b01, 3'd4, 3'd0);
    expectAt(R + 1043, "t2_soft_exit",    4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    stepTo(R + 1041);
    pll_locked = 1'b1;
    stepTo(R + 1042);
    soft_rst_req = 1'b1;
    stepTo(R + 1043);
    soft_rst_req = 1'b0;

    // Stage 2 never acknowledges.
    applyReset();
    applyStimulus(1'b1, 4'b1011);
    expectAt(R + 33,  "t3_stage2",      4'b1000, 0, 0, 2'b00, 3'd2, 3'd2);
    expectAt(R + 288, "t3_pre_timeout", 4'b1000, 0, 0, 2'b00, 3'd2, 3'd2);
    expectAt(R + 289, "t3_ack_timeout", 4'b1111, 0, 1, 2'b10, 3'd4, 3'd0);
    stepTo(R + 290);

    // Ack for stage 0 only during cnt 0..3: ignored, then timeout.
    applyReset();
    applyStimulus(1'b1, 4'b0000);
    expectAt(R + 17,  "t5_stage0",        4'b1110, 0, 0, 2'b00, 3'd2, 3'd0);
    expectAt(R + 272, "t5_early_ignored", 4'b1110, 0, 0, 2'b00, 3'd2, 3'd0);
    expectAt(R + 273, "t5_ack_timeout",   4'b1111, 0, 1, 2'b10, 3'd4, 3'd0);
    stepTo(R + 17);
    ack_force = 4'b0001;
    stepTo(R + 21);
    ack_force = 4'b0000;
    stepTo(R + 274);

    // Ack arriving exactly on the timeout cycle: the advance wins.
    applyReset();
    applyStimulus(1'b1, 4'b0000);
    expectAt(R + 273, "t5_advance_wins", 4'b1100, 0, 0, 2'b00, 3'd2, 3'd1);
    stepTo(R + 272);
    ack_force = 4'b0001;
    stepTo(R + 273);
    ack_force = 4'b0000;
    stepTo(R + 274);

    // Synchronous reset asserted in the middle of RELEASE.
    applyReset();
    applyStimulus(1'b1, 4'b1111);
    expectAt(R + 30, "t5_mid_release", 4'b1100, 0, 0, 2'b00, 3'd2, 3'd1);
    expectAt(R + 31, "t5_rst_release", 4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    stepTo(R + 30);
    rst = 1'b1;
    stepTo(R + 31);

    // Soft request with lock loss in RUN, then a soft request in HOLD that
    // restarts the hold count.
    applyReset();
    applyStimulus(1'b1, 4'b1111);
    H  = R + 53;
    H2 = H + 6;
    expectAt(R + 49,  "t5_run",            4'b0000, 1, 0, 2'b00, 3'd3, 3'd0);
    expectAt(H,       "t5_soft_lock_loss", 4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    expectAt(H2 + 15, "t5_hold_restarted", 4'b1111, 0, 0, 2'b00, 3'd0, 3'd0);
    expectAt(H2 + 16, "t5_wait_restarted", 4'b1111, 0, 0, 2'b00, 3'd1, 3'd0);
    stepTo(R + 52);
    soft_rst_req = 1'b1;
    pll_locked   = 1'b0;
    stepTo(H);
    soft_rst_req = 1'b0;
    pll_locked   = 1'b1;
    stepTo(H + 5);
    soft_rst_req = 1'b1;
    stepTo(H2);
    soft_rst_req = 1'b0;
    stepTo(H2 + 17);

    // Anything left in the queue was never reached by the monitor.
    stepTo(cyc + 3);
    if (q.size() != 0) begin
      total += q.size();
      bad   += q.size();
      $display("[TB] FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: stimulus did not complete, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
